// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the load/store path.
// Each access holds mem_en for WAIT_CYCLES+1 cycles and finishes with a one-cycle valid pulse.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              pc_hold,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic              ls_byte,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic              mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DATA = 2'd2} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

  state_t            state_r, state_s;
  logic [3:0]        cnt_r, cnt_s;
  logic              last_gnt_r, last_gnt_s;   // 1 = last grant went to DATA
  logic              mem_en_r, mem_en_s;
  logic              mem_we_r, mem_we_s;
  logic              mem_byte_r, mem_byte_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
  logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
  logic [DATA_W-1:0] ls_rdata_r, ls_rdata_s;
  logic              if_valid_r, if_valid_s;
  logic              ls_valid_r, ls_valid_s;

  // Next-state, grant and completion logic
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    last_gnt_s  = last_gnt_r;
    mem_en_s    = mem_en_r;
    mem_we_s    = mem_we_r;
    mem_byte_s  = mem_byte_r;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    if_rdata_s  = if_rdata_r;
    ls_rdata_s  = ls_rdata_r;
    if_valid_s  = 1'b0;
    ls_valid_s  = 1'b0;
    case (state_r)
      IDLE: begin
        // Data wins a tie unless it was served last, so neither side starves
        if (ls_req && (!if_req || !last_gnt_r)) begin
          state_s     = DATA;
          cnt_s       = 4'd0;
          last_gnt_s  = 1'b1;
          mem_en_s    = 1'b1;
          mem_we_s    = ls_we;
          mem_byte_s  = ls_byte;
          mem_addr_s  = ls_addr;
          mem_wdata_s = ls_wdata;
        end else if (if_req) begin
          state_s    = FETCH;
          cnt_s      = 4'd0;
          last_gnt_s = 1'b0;
          mem_en_s   = 1'b1;
          mem_we_s   = 1'b0;
          mem_byte_s = 1'b0;
          mem_addr_s = if_addr;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH, DATA: begin
        if (cnt_r == WAIT_LAST) begin
          state_s  = IDLE;
          cnt_s    = 4'd0;
          mem_en_s = 1'b0;
          mem_we_s = 1'b0;
          if (state_r == FETCH) begin
            if_rdata_s = mem_rdata;
            if_valid_s = 1'b1;
          end else begin
            ls_valid_s = 1'b1;
            if (mem_we_r) begin
              ls_rdata_s = ls_rdata_r;
            end else if (mem_byte_r) begin
              ls_rdata_s = {{(DATA_W-8){1'b0}}, mem_rdata[7:0]};
            end else begin
              ls_rdata_s = mem_rdata;
            end
          end
        end else begin
          cnt_s = cnt_r + 4'd1;
        end
      end
      default: begin
        state_s  = IDLE;
        cnt_s    = 4'd0;
        mem_en_s = 1'b0;
        mem_we_s = 1'b0;
      end
    endcase
  end

  // State and registered-output update with asynchronous abort on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      last_gnt_r  <= 1'b0;
      mem_en_r    <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_byte_r  <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      if_rdata_r  <= {DATA_W{1'b0}};
      ls_rdata_r  <= {DATA_W{1'b0}};
      if_valid_r  <= 1'b0;
      ls_valid_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      last_gnt_r  <= last_gnt_s;
      mem_en_r    <= mem_en_s;
      mem_we_r    <= mem_we_s;
      mem_byte_r  <= mem_byte_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      if_rdata_r  <= if_rdata_s;
      ls_rdata_r  <= ls_rdata_s;
      if_valid_r  <= if_valid_s;
      ls_valid_r  <= ls_valid_s;
    end
  end

  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_byte  = mem_byte_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_rdata  = if_rdata_r;
  assign ls_rdata  = ls_rdata_r;
  assign if_valid  = if_valid_r;
  assign ls_valid  = ls_valid_r;
  assign pc_hold   = if_req & ~if_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT_CYCLES=2 main instance plus a WAIT_CYCLES=0 instance.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, ls_byte = 1'b0;
  logic [31:0] if_addr = 32'h0, ls_addr = 32'h0, ls_wdata = 32'h0, mem_rdata = 32'h0;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic        if_valid, ls_valid, pc_hold, mem_en, mem_we, mem_byte;

  logic        z_if_req = 1'b0;
  logic [31:0] z_if_addr = 32'h0, z_mem_rdata = 32'h0;
  logic [31:0] z_if_rdata, z_ls_rdata, z_mem_addr, z_mem_wdata;
  logic        z_if_valid, z_ls_valid, z_pc_hold, z_mem_en, z_mem_we, z_mem_byte;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .pc_hold(pc_hold),
    .ls_req(ls_req), .ls_we(ls_we), .ls_byte(ls_byte), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_rdata(ls_rdata), .ls_valid(ls_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_rdata(z_if_rdata), .if_valid(z_if_valid),
    .pc_hold(z_pc_hold),
    .ls_req(1'b0), .ls_we(1'b0), .ls_byte(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0),
    .ls_rdata(z_ls_rdata), .ls_valid(z_ls_valid),
    .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_byte(z_mem_byte), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Runs one access on the main instance; request already driven. Drops requests on completion.
  task automatic run_access(input bit is_ls, output int en_n, output int lat,
                            output logic [31:0] addr_s, output logic we_s, output logic byte_s,
                            output logic [31:0] wdata_s, output logic hold_s);
    en_n = 0; lat = 0; addr_s = 32'h0; we_s = 1'b0; byte_s = 1'b0; wdata_s = 32'h0; hold_s = 1'b1;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge clk);
      if (mem_en) begin
        en_n++; addr_s = mem_addr; we_s = mem_we; byte_s = mem_byte; wdata_s = mem_wdata;
      end
      if (is_ls ? ls_valid : if_valid) begin
        lat = i;
        hold_s = pc_hold;
        if_req = 1'b0;
        ls_req = 1'b0;
      end
    end
    if (lat == 0) check_eq("access_timeout", 32'd0, 32'd1);
  endtask

  int          en_n, lat, nv, both, last_t, z_en, z_v, z_first;
  logic [31:0] a_s, wd_s;
  logic        we_s, by_s, hold_s;
  logic [3:0]  order;

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_mem_en",   {31'd0, mem_en},   32'd0);
    check_eq("rst_if_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_ls_valid", {31'd0, ls_valid}, 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_if_rdata", if_rdata, 32'h0);
    check_eq("rst_ls_rdata", ls_rdata, 32'h0);
    check_eq("rst_z_mem_en", {31'd0, z_mem_en}, 32'd0);
    rst = 1'b0;

    // Fetch only
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100; mem_rdata = 32'hDEADBEEF;
    #1 check_eq("fetch_pc_hold_pending", {31'd0, pc_hold}, 32'd1);
    run_access(1'b0, en_n, lat, a_s, we_s, by_s, wd_s, hold_s);
    check_eq("fetch_en_cycles", en_n, 32'd3);
    check_eq("fetch_latency",   lat,  32'd4);
    check_eq("fetch_addr",      a_s,  32'h100);
    check_eq("fetch_we",        {31'd0, we_s},   32'd0);
    check_eq("fetch_pc_hold_at_valid", {31'd0, hold_s}, 32'd0);
    check_eq("fetch_rdata",     if_rdata, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("fetch_valid_pulse", {31'd0, if_valid}, 32'd0);
    check_eq("fetch_idle_en",     {31'd0, mem_en},   32'd0);

    // Byte load
    ls_req = 1'b1; ls_we = 1'b0; ls_byte = 1'b1; ls_addr = 32'h2003; mem_rdata = 32'h123456A5;
    run_access(1'b1, en_n, lat, a_s, we_s, by_s, wd_s, hold_s);
    check_eq("bload_en_cycles", en_n, 32'd3);
    check_eq("bload_latency",   lat,  32'd4);
    check_eq("bload_addr",      a_s,  32'h2003);
    check_eq("bload_byte",      {31'd0, by_s}, 32'd1);
    check_eq("bload_rdata",     ls_rdata, 32'h000000A5);
    check_eq("bload_if_rdata_hold", if_rdata, 32'hDEADBEEF);
    @(negedge clk);
    check_eq("bload_valid_pulse", {31'd0, ls_valid}, 32'd0);

    // Word store
    ls_req = 1'b1; ls_we = 1'b1; ls_byte = 1'b0; ls_addr = 32'h40; ls_wdata = 32'hCAFEF00D;
    mem_rdata = 32'h11111111;
    run_access(1'b1, en_n, lat, a_s, we_s, by_s, wd_s, hold_s);
    check_eq("store_en_cycles", en_n, 32'd3);
    check_eq("store_we",        {31'd0, we_s}, 32'd1);
    check_eq("store_byte",      {31'd0, by_s}, 32'd0);
    check_eq("store_addr",      a_s,  32'h40);
    check_eq("store_wdata",     wd_s, 32'hCAFEF00D);
    check_eq("store_rdata_hold", ls_rdata, 32'h000000A5);
    @(negedge clk);
    check_eq("store_we_after",  {31'd0, mem_we}, 32'd0);

    // Both requesters held from reset: alternation starting with DATA
    rst = 1'b1;
    @(negedge clk);
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_byte = 1'b0; mem_rdata = 32'h5A5A5A5A;
    rst = 1'b0;
    nv = 0; both = 0; last_t = 0; order = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (ls_valid && if_valid) both++;
      if (ls_valid || if_valid) begin
        order = {order[2:0], ls_valid};
        if (last_t == 0) check_eq("arb_first_valid", i, 32'd4);
        else             check_eq("arb_interval", i - last_t, 32'd4);
        last_t = i;
        nv++;
      end
    end
    if_req = 1'b0; ls_req = 1'b0;
    check_eq("arb_count", nv, 32'd4);
    check_eq("arb_order", {28'd0, order}, 32'h0000000A);
    check_eq("arb_exclusive", both, 32'd0);
    @(negedge clk);

    // Reset in the middle of a fetch
    if_req = 1'b1; if_addr = 32'h300; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    @(negedge clk);
    check_eq("abort_en_before", {31'd0, mem_en}, 32'd1);
    rst = 1'b1;
    #1 check_eq("abort_en_drop", {31'd0, mem_en}, 32'd0);
    @(negedge clk);
    check_eq("abort_no_valid", {31'd0, if_valid}, 32'd0);
    rst = 1'b0;
    run_access(1'b0, en_n, lat, a_s, we_s, by_s, wd_s, hold_s);
    check_eq("restart_en_cycles", en_n, 32'd3);
    check_eq("restart_latency",   lat,  32'd4);
    check_eq("restart_rdata",     if_rdata, 32'h0BADF00D);

    // WAIT_CYCLES=0 instance: back-to-back fetches every 2 cycles
    @(negedge clk);
    z_if_req = 1'b1; z_if_addr = 32'h200; z_mem_rdata = 32'h00000055;
    z_en = 0; z_v = 0; z_first = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (z_mem_en) z_en++;
      if (z_if_valid) begin
        z_v++;
        if (z_first == 0) z_first = i;
      end
    end
    z_if_req = 1'b0;
    check_eq("w0_en_cycles", z_en, 32'd4);
    check_eq("w0_valids",    z_v,  32'd4);
    check_eq("w0_first_valid", z_first, 32'd2);
    check_eq("w0_rdata",     z_if_rdata, 32'h00000055);
    check_eq("w0_addr",      z_mem_addr, 32'h200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
